// File: rtl/win_lose_pkg.sv
// Shared types and constants for the win/lose game datapath.
package win_lose_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STOP1  = 2'd1,
    STOP2  = 2'd2,
    RESULT = 2'd3
  } state_e;

  localparam int                 DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, level debounce, and a
// one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the
  // accepted level; any agreement (a bounce) restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, accepted level, edge-detect delay and debounce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/reel_stop_judge.sv
// Reel stop sequencer: freezes the three reels on successive presses,
// judges the frozen triple and keeps a saturating win tally.
module reel_stop_judge
  import win_lose_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESULT_CYCLES   = 150000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  input  logic [DIGIT_W-1:0] count1,
  input  logic [DIGIT_W-1:0] count2,
  input  logic [DIGIT_W-1:0] count3,
  output logic [DIGIT_W-1:0] disp1,
  output logic [DIGIT_W-1:0] disp2,
  output logic [DIGIT_W-1:0] disp3,
  output logic               busy,
  output logic               win,
  output logic               lose,
  output logic [7:0]         win_total
);

  localparam int TMR_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESULT_CYCLES - 1);

  // The wrap value (10) or anything above 9 is shown and stored as 0.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v);
    return (v > MAX_DIGIT) ? '0 : v;
  endfunction

  // Tally increment that holds at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic               press;
  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [DIGIT_W-1:0] live1, live2, live3;
  logic               win_q, win_d, lose_q, lose_d;
  logic [7:0]         total_q, total_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               match;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn),
    .press_o(press)
  );

  assign live1 = clamp_digit(count1);
  assign live2 = clamp_digit(count2);
  assign live3 = clamp_digit(count3);

  // Next state: live reels keep tracking, a press simply stops the next reel
  // from updating, so the value present on the press cycle is what is held.
  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    win_d   = win_q;
    lose_d  = lose_q;
    total_d = total_q;
    tmr_d   = tmr_q;
    match   = 1'b0;
    case (state_q)
      IDLE: begin
        r1_d   = live1;
        r2_d   = live2;
        r3_d   = live3;
        win_d  = 1'b0;
        lose_d = 1'b0;
        if (press) state_d = STOP1;
      end
      STOP1: begin
        r2_d = live2;
        r3_d = live3;
        if (press) state_d = STOP2;
      end
      STOP2: begin
        r3_d = live3;
        if (press) begin
          match   = (r1_q == r2_q) && (r2_q == live3);
          state_d = RESULT;
          tmr_d   = '0;
          win_d   = match;
          lose_d  = ~match;
          if (match) total_d = sat_inc(total_q);
        end
      end
      RESULT: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (press || (tmr_q == TMR_LAST)) begin
          state_d = IDLE;
          win_d   = 1'b0;
          lose_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, reel digits, result flags, tally and result timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      total_q <= 8'd0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      total_q <= total_d;
      tmr_q   <= tmr_d;
    end
  end

  assign disp1     = r1_q;
  assign disp2     = r2_q;
  assign disp3     = r3_q;
  assign busy      = (state_q == STOP1) || (state_q == STOP2);
  assign win       = win_q;
  assign lose      = lose_q;
  assign win_total = total_q;

endmodule

// File: tb/tb_reel_stop_judge.sv
// Directed bench for reel_stop_judge with short debounce/result timers.
module tb_reel_stop_judge;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic [3:0] count1, count2, count3;
  logic [3:0] disp1, disp2, disp3;
  logic       busy, win, lose;
  logic [7:0] win_total;

  int checks = 0;
  int errors = 0;

  reel_stop_judge #(
    .DEBOUNCE_CYCLES(4),
    .RESULT_CYCLES  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .count1   (count1),
    .count2   (count2),
    .count3   (count3),
    .disp1    (disp1),
    .disp2    (disp2),
    .disp3    (disp3),
    .busy     (busy),
    .win      (win),
    .lose     (lose),
    .win_total(win_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press is accepted 2 sync + 4 debounce edges after the button rises and
  // the FSM moves on the 7th edge.
  task automatic press_hold();
    btn = 1'b1;
    step(7);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    step(7);
  endtask

  task automatic set_counts(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    count1 = a;
    count2 = b;
    count3 = c;
  endtask

  task automatic play_game();
    for (int i = 0; i < 3; i++) begin
      press_hold();
      release_btn();
    end
    step(16);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    set_counts(4'd3, 4'd5, 4'd7);
    step(2);
    chk("rst_disp1", 32'(disp1), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_win_lose", 32'({win, lose}), 0);
    chk("rst_total", 32'(win_total), 0);

    // Idle: live display of held counts.
    rst_n = 1'b1;
    step(3);
    chk("idle_disp", 32'({disp1, disp2, disp3}), 32'h357);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_win_lose", 32'({win, lose}), 0);
    chk("idle_total", 32'(win_total), 0);

    // Winning game 6/6/6.
    set_counts(4'd6, 4'd6, 4'd6);
    step(1);
    press_hold();
    chk("p1_disp1", 32'(disp1), 6);
    chk("p1_busy", 32'(busy), 1);
    set_counts(4'd1, 4'd4, 4'd6);
    step(1);
    chk("stop1_frozen1", 32'(disp1), 6);
    chk("stop1_live2", 32'(disp2), 4);
    count2 = 4'd6;
    release_btn();
    press_hold();
    chk("p2_busy", 32'(busy), 1);
    release_btn();
    press_hold();
    chk("win_flag", 32'({win, lose}), 32'b10);
    chk("win_total1", 32'(win_total), 1);
    chk("result_busy", 32'(busy), 0);
    chk("result_disp3", 32'(disp3), 6);
    set_counts(4'd1, 4'd2, 4'd3);
    release_btn();
    chk("result_frozen", 32'({disp1, disp2, disp3}), 32'h666);
    step(8);
    chk("timeout_minus1_win", 32'(win), 1);
    step(1);
    chk("timeout_win_drop", 32'({win, lose}), 0);
    step(1);
    chk("timeout_live", 32'({disp1, disp2, disp3}), 32'h123);

    // Losing game 2/2/9, left early by a fourth press.
    set_counts(4'd2, 4'd2, 4'd9);
    step(1);
    press_hold();
    release_btn();
    press_hold();
    release_btn();
    press_hold();
    chk("lose_flag", 32'({win, lose}), 32'b01);
    chk("lose_total", 32'(win_total), 1);
    release_btn();
    press_hold();
    chk("early_exit", 32'({win, lose}), 0);
    chk("early_exit_busy", 32'(busy), 0);
    release_btn();
    chk("no_new_game", 32'(busy), 0);

    // Bouncing button: one press only.
    set_counts(4'd4, 4'd5, 4'd6);
    btn = 1'b1; step(2);
    btn = 1'b0; step(2);
    btn = 1'b1; step(2);
    btn = 1'b0; step(2);
    chk("bounce_no_press", 32'(busy), 0);
    btn = 1'b1;
    step(10);
    chk("bounce_one_press", 32'(busy), 1);
    chk("bounce_disp1", 32'(disp1), 4);
    set_counts(4'd9, 4'd8, 4'd6);
    step(1);
    chk("bounce_frozen1", 32'(disp1), 4);
    chk("bounce_live2", 32'(disp2), 8);
    count2 = 4'd5;
    release_btn();
    press_hold();
    chk("stop2_disp2", 32'(disp2), 5);
    chk("stop2_busy", 32'(busy), 1);

    // Asynchronous reset in STOP2.
    #2;
    rst_n = 1'b0;
    btn   = 1'b0;
    #1;
    chk("async_rst_disp", 32'({disp1, disp2, disp3}), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_total", 32'(win_total), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);

    // Wrap value 10 clamps to 0 live and on capture.
    set_counts(4'd10, 4'd0, 4'd10);
    step(1);
    chk("clamp_live1", 32'(disp1), 0);
    chk("clamp_live3", 32'(disp3), 0);
    press_hold();
    chk("clamp_cap1", 32'(disp1), 0);
    release_btn();
    press_hold();
    release_btn();
    press_hold();
    chk("zero_win", 32'({win, lose}), 32'b10);
    chk("zero_total", 32'(win_total), 1);
    release_btn();
    step(20);
    chk("zero_idle", 32'(win), 0);

    // Saturating tally.
    set_counts(4'd5, 4'd5, 4'd5);
    for (int g = 0; g < 254; g++) play_game();
    chk("total_255", 32'(win_total), 255);
    press_hold();
    release_btn();
    press_hold();
    release_btn();
    press_hold();
    chk("sat_win", 32'(win), 1);
    chk("sat_total", 32'(win_total), 255);
    release_btn();
    step(16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
